// File: rtl/ccr_save_restore_ctrl.sv
// Interrupt entry / RTI exit sequencer: pushes PC and CCR, fetches the handler vector,
// or pops CCR and PC back, driving a single-port data memory with req/ack handshake.
module ccr_save_restore_ctrl #(
  parameter logic [31:0] IRQ_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq_req,
  input  logic        rti_req,
  input  logic [31:0] pc_in,
  input  logic [3:0]  ccr_in,
  input  logic [31:0] sp_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        sp_dec,
  output logic        sp_inc,
  output logic        ccr_load_stack,
  output logic [3:0]  ccr_stack_flags,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        stall,
  output logic        irq_ack
);

  // state     | meaning
  // IDLE      | waiting for rti_req (priority) or irq_req
  // PUSH_PC   | write saved PC at SP
  // PUSH_CCR  | write saved flags at SP-1
  // FETCH_VEC | read handler address from IRQ_VEC
  // POP_CCR   | read flags from SP+1
  // POP_PC    | read return PC from SP+2
  // DONE      | one-cycle completion, irq_ack on the interrupt path
  typedef enum logic [2:0] {
    IDLE,
    PUSH_PC,
    PUSH_CCR,
    FETCH_VEC,
    POP_CCR,
    POP_PC,
    DONE
  } state_t;

  state_t      state_q;
  logic [31:0] sp_q;
  logic [31:0] pc_q;
  logic [3:0]  ccr_q;
  logic        irq_path_q;

  // sp_q tracks the stack pointer locally so sp_in is sampled only once per sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sp_q       <= '0;
      pc_q       <= '0;
      ccr_q      <= '0;
      irq_path_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rti_req || irq_req) begin
            sp_q       <= sp_in;
            pc_q       <= pc_in;
            ccr_q      <= ccr_in;
            irq_path_q <= !rti_req;
            state_q    <= rti_req ? POP_CCR : PUSH_PC;
          end
        end
        PUSH_PC: begin
          if (mem_ack) begin
            sp_q    <= sp_q - 32'd1;
            state_q <= PUSH_CCR;
          end
        end
        PUSH_CCR: begin
          if (mem_ack) begin
            sp_q    <= sp_q - 32'd1;
            state_q <= FETCH_VEC;
          end
        end
        FETCH_VEC: begin
          if (mem_ack) state_q <= DONE;
        end
        POP_CCR: begin
          if (mem_ack) begin
            sp_q    <= sp_q + 32'd1;
            state_q <= POP_PC;
          end
        end
        POP_PC: begin
          if (mem_ack) begin
            sp_q    <= sp_q + 32'd1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes fire in the ack cycle itself so read data is forwarded without a register stage.
  always_comb begin
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    sp_dec          = 1'b0;
    sp_inc          = 1'b0;
    ccr_load_stack  = 1'b0;
    ccr_stack_flags = '0;
    pc_load         = 1'b0;
    pc_out          = '0;
    irq_ack         = 1'b0;
    case (state_q)
      PUSH_PC: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = pc_q;
        sp_dec    = mem_ack;
      end
      PUSH_CCR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = {28'b0, ccr_q};
        sp_dec    = mem_ack;
      end
      FETCH_VEC: begin
        mem_req  = 1'b1;
        mem_addr = IRQ_VEC;
        pc_load  = mem_ack;
        pc_out   = mem_ack ? mem_rdata : 32'd0;
      end
      POP_CCR: begin
        mem_req         = 1'b1;
        mem_addr        = sp_q + 32'd1;
        sp_inc          = mem_ack;
        ccr_load_stack  = mem_ack;
        ccr_stack_flags = mem_ack ? mem_rdata[3:0] : 4'd0;
      end
      POP_PC: begin
        mem_req  = 1'b1;
        mem_addr = sp_q + 32'd1;
        sp_inc   = mem_ack;
        pc_load  = mem_ack;
        pc_out   = mem_ack ? mem_rdata : 32'd0;
      end
      DONE:    irq_ack = irq_path_q;
      default: ;
    endcase
  end

  // In IDLE the freeze follows the request lines directly, but never while reset is held.
  assign stall = (state_q != IDLE) || (rst_n && (irq_req || rti_req));

endmodule

// File: tb/tb_ccr_save_restore_ctrl.sv
// Bench for ccr_save_restore_ctrl: table vectors, reset/abort sequence, and randomized
// interrupt/RTI traffic checked against a stack-level reference model.
module tb_ccr_save_restore_ctrl;
  localparam logic [31:0] VEC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq_req = 1'b0, rti_req = 1'b0;
  logic [31:0] pc_in = '0, sp_in = '0;
  logic [3:0]  ccr_in = '0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        sp_dec, sp_inc, ccr_load_stack, pc_load, stall, irq_ack;
  logic [3:0]  ccr_stack_flags;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  ccr_save_restore_ctrl #(.IRQ_VEC(VEC)) dut (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .rti_req(rti_req),
    .pc_in(pc_in), .ccr_in(ccr_in), .sp_in(sp_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sp_dec(sp_dec), .sp_inc(sp_inc), .ccr_load_stack(ccr_load_stack),
    .ccr_stack_flags(ccr_stack_flags), .pc_load(pc_load), .pc_out(pc_out),
    .stall(stall), .irq_ack(irq_ack)
  );

  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} acc_t;
  typedef struct {logic [31:0] pc; logic [3:0] ccr;} frame_t;
  typedef struct {
    int mode; logic [31:0] sp; logic [31:0] pc; logic [3:0] ccr;
    int w0; int w1; int w2;
    logic [31:0] a0; logic [31:0] a1; logic [31:0] fpc; int lat;
  } vec_t;

  int tests = 0, fails = 0;
  acc_t acc_log[$], acc_exp[$];
  logic [31:0] pc_log[$], pc_exp[$];
  logic [3:0]  ccr_log[$], ccr_exp[$];
  int n_dec, n_inc, n_ack, ack_idx, last_stall, cyc, acc_k, wcnt;
  int waits[5];
  bit spurious = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic pend, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({mem_req, mem_we, sp_dec, sp_inc, ccr_load_stack, pc_load,
                             stall, irq_ack, ccr_stack_flags}), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_pc_out"}, pc_out, 32'd0);
  endtask

  task automatic preset_mem();
    mem.delete();
    mem[32'h0]   = 32'h200;
    mem[32'hFF]  = 32'hA;
    mem[32'h100] = 32'h44;
  endtask

  task automatic clear_logs();
    acc_log.delete(); pc_log.delete(); ccr_log.delete();
    n_dec = 0; n_inc = 0; n_ack = 0; ack_idx = -1; last_stall = -1;
    acc_k = 0; wcnt = 0; pend = 1'b0;
  endtask

  // Memory responder plus monitor for one cycle; called at a falling edge.
  task automatic respond_sample();
    if (mem_req) begin
      if (acc_k < 5 && wcnt < waits[acc_k]) begin mem_ack = 1'b0; wcnt++; end
      else mem_ack = 1'b1;
      mem_rdata = (mem_ack && !mem_we) ? rd(mem_addr) : $urandom;
    end else begin
      mem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end
    #1;
    if (mem_req) chk("stall_in_mem_state", 32'(stall), 32'd1);
    if (pend && mem_req) begin
      chk("hold_addr", mem_addr, prev_addr);
      chk("hold_we", 32'(mem_we), 32'(prev_we));
      chk("hold_wdata", mem_wdata, prev_wdata);
    end
    pend = mem_req && !mem_ack;
    prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
    if (mem_req && mem_ack) begin
      acc_log.push_back('{mem_addr, mem_we, mem_wdata});
      if (mem_we) mem[mem_addr] = mem_wdata;
      acc_k++;
      wcnt = 0;
    end
    if (sp_dec) n_dec++;
    if (sp_inc) n_inc++;
    if (ccr_load_stack) ccr_log.push_back(ccr_stack_flags);
    if (pc_load) pc_log.push_back(pc_out);
    if (irq_ack) begin n_ack++; ack_idx = cyc; end
    if (stall) last_stall = cyc;
  endtask

  // mode 0: interrupt, 1: RTI, 2: both requested together
  task automatic run(input int mode, input logic [31:0] sp, input logic [31:0] pc,
                     input logic [3:0] ccr);
    int exp_last;
    logic [31:0] v;
    clear_logs();
    acc_exp.delete(); pc_exp.delete(); ccr_exp.delete();
    if (mode != 0) begin
      acc_exp.push_back('{sp + 32'd1, 1'b0, 32'd0});
      acc_exp.push_back('{sp + 32'd2, 1'b0, 32'd0});
      v = rd(sp + 32'd1);
      ccr_exp.push_back(v[3:0]);
      pc_exp.push_back(rd(sp + 32'd2));
    end
    if (mode != 1) begin
      acc_exp.push_back('{sp, 1'b1, pc});
      acc_exp.push_back('{sp - 32'd1, 1'b1, {28'b0, ccr}});
      acc_exp.push_back('{VEC, 1'b0, 32'd0});
      if (VEC == sp) v = pc;
      else if (VEC == sp - 32'd1) v = {28'b0, ccr};
      else v = rd(VEC);
      pc_exp.push_back(v);
    end
    exp_last = (mode == 0) ? 4 : (mode == 1) ? 3 : 8;
    foreach (acc_exp[i]) exp_last += waits[i];

    @(negedge clk);
    sp_in = sp; pc_in = pc; ccr_in = ccr;
    irq_req = (mode != 1); rti_req = (mode != 0);
    cyc = 0;
    respond_sample();
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      cyc = c;
      if (c == 1) begin
        rti_req = 1'b0;
        if (mode != 2) begin sp_in = $urandom; pc_in = $urandom; ccr_in = 4'($urandom); end
      end
      respond_sample();
      if (irq_ack) irq_req = 1'b0;
      if (!stall) break;
    end
    if (stall) begin
      chk("sequence_timeout", 32'(stall), 32'd0);
      irq_req = 1'b0;
    end

    chk("access_count", 32'(acc_log.size()), 32'(acc_exp.size()));
    for (int i = 0; i < acc_log.size() && i < acc_exp.size(); i++) begin
      chk("access_addr", acc_log[i].addr, acc_exp[i].addr);
      chk("access_we", 32'(acc_log[i].we), 32'(acc_exp[i].we));
      if (acc_exp[i].we) chk("access_wdata", acc_log[i].wdata, acc_exp[i].wdata);
    end
    chk("ccr_load_count", 32'(ccr_log.size()), 32'(ccr_exp.size()));
    for (int i = 0; i < ccr_log.size() && i < ccr_exp.size(); i++)
      chk("ccr_stack_flags", 32'(ccr_log[i]), 32'(ccr_exp[i]));
    chk("pc_load_count", 32'(pc_log.size()), 32'(pc_exp.size()));
    for (int i = 0; i < pc_log.size() && i < pc_exp.size(); i++)
      chk("pc_out", pc_log[i], pc_exp[i]);
    chk("sp_dec_count", 32'(n_dec), (mode != 1) ? 32'd2 : 32'd0);
    chk("sp_inc_count", 32'(n_inc), (mode != 0) ? 32'd2 : 32'd0);
    chk("irq_ack_count", 32'(n_ack), (mode != 1) ? 32'd1 : 32'd0);
    chk("latency", 32'(last_stall), 32'(exp_last));
    if (mode != 1) chk("irq_ack_in_done", 32'(ack_idx), 32'(exp_last));
  endtask

  vec_t vt[7];
  frame_t stk[$];
  frame_t fr;
  logic [31:0] sp_model, rpc;
  logic [3:0] rccr;
  int mode;
  bit found;

  initial begin
    vt[0] = '{0, 32'h100, 32'h40, 4'h5, 0, 0, 0, 32'h100, 32'hFF, 32'h200, 4};
    vt[1] = '{1, 32'hFE, 32'h0, 4'h0, 0, 0, 0, 32'hFF, 32'h100, 32'h44, 3};
    vt[2] = '{0, 32'h100, 32'h40, 4'h5, 0, 3, 0, 32'h100, 32'hFF, 32'h200, 7};
    vt[3] = '{0, 32'h0, 32'h80, 4'hF, 0, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'h80, 4};
    vt[4] = '{1, 32'hFFFF_FFFE, 32'h0, 4'h0, 1, 2, 0, 32'hFFFF_FFFF, 32'h0, 32'h200, 6};
    vt[5] = '{2, 32'hFE, 32'h40, 4'h3, 0, 0, 0, 32'hFF, 32'h100, 32'h200, 8};
    vt[6] = '{1, 32'hFE, 32'h0, 4'h0, 2, 0, 0, 32'hFF, 32'h100, 32'h44, 5};
    foreach (waits[i]) waits[i] = 0;

    irq_req = 1'b1; rti_req = 1'b1; mem_ack = 1'b1;
    #12;
    check_zero("reset");
    irq_req = 1'b0; rti_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    foreach (vt[i]) begin
      preset_mem();
      foreach (waits[k]) waits[k] = 0;
      waits[0] = vt[i].w0; waits[1] = vt[i].w1; waits[2] = vt[i].w2;
      run(vt[i].mode, vt[i].sp, vt[i].pc, vt[i].ccr);
      if (acc_log.size() > 1) begin
        chk("tbl_addr0", acc_log[0].addr, vt[i].a0);
        chk("tbl_addr1", acc_log[1].addr, vt[i].a1);
      end
      if (pc_log.size() > 0) chk("tbl_final_pc", pc_log[$], vt[i].fpc);
      chk("tbl_latency", 32'(last_stall), 32'(vt[i].lat));
    end

    // Reset asserted while POP_PC waits for its ack.
    preset_mem();
    foreach (waits[k]) waits[k] = 0;
    waits[1] = 4;
    clear_logs();
    found = 1'b0;
    @(negedge clk);
    sp_in = 32'hFE; rti_req = 1'b1; cyc = 0;
    respond_sample();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      cyc = c;
      rti_req = 1'b0;
      if (acc_k == 1 && mem_req) begin found = 1'b1; break; end
      respond_sample();
    end
    chk("reach_pop_pc", 32'(found), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h44; rst_n = 1'b0; irq_req = 1'b1;
    #1;
    check_zero("abort");
    chk("abort_no_pc_load", 32'(pc_log.size()), 32'd0);
    chk("abort_ccr_popped", 32'(ccr_log.size()), 32'd1);
    @(negedge clk); #1;
    check_zero("abort_hold");
    irq_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_idle", 32'({mem_req, stall}), 32'd0);
    preset_mem();
    foreach (waits[k]) waits[k] = 0;
    run(1, 32'hFE, 32'h0, 4'h0);

    // Random traffic: interrupts push frames, RTIs must return the most recent frame.
    spurious = 1'b1;
    sp_model = 32'h0000_8000;
    stk.delete();
    for (int it = 0; it < 40; it++) begin
      mode = (stk.size() == 0 || (stk.size() < 6 && $urandom_range(0, 1) == 1)) ? 0 : 1;
      foreach (waits[k]) waits[k] = $urandom_range(0, 2);
      rpc = $urandom;
      rccr = 4'($urandom);
      run(mode, sp_model, rpc, rccr);
      if (mode == 0) begin
        stk.push_back('{rpc, rccr});
        sp_model = sp_model - 32'd2;
      end else begin
        fr = stk.pop_back();
        if (pc_log.size() > 0) chk("rand_rti_pc", pc_log[$], fr.pc);
        if (ccr_log.size() > 0) chk("rand_rti_ccr", 32'(ccr_log[$]), 32'(fr.ccr));
        sp_model = sp_model + 32'd2;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ccr_save_restore_ctrl.md
CCR_SAVE_RESTORE_CTRL -- requirements
Module: ccr_save_restore_ctrl

Interface
REQ-001 The block SHALL have parameter IRQ_VEC, default 32'h0000_0000, meaning the data-memory address holding the interrupt handler address.
REQ-002 The block SHALL have clk  input  1  system clock, all state on the rising edge.
REQ-003 The block SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have irq_req  input  1  level interrupt request, held until irq_ack.
REQ-005 The block SHALL have rti_req  input  1  RTI instruction in decode.
REQ-006 The block SHALL have pc_in  input  32  return PC to save on interrupt.
REQ-007 The block SHALL have ccr_in  input  4  current flags {V,C,N,Z}.
REQ-008 The block SHALL have sp_in  input  32  current stack pointer.
REQ-009 The block SHALL have mem_req, mem_we  output  1 each  data-memory request and write-enable.
REQ-010 The block SHALL have mem_addr, mem_wdata  output  32 each  memory address and write data.
REQ-011 The block SHALL have mem_ack  input  1  and mem_rdata  input  32  memory completion and read data.
REQ-012 The block SHALL have sp_dec, sp_inc  output  1 each  one-cycle SP adjust strobes.
REQ-013 The block SHALL have ccr_load_stack  output  1  and ccr_stack_flags  output  4  CCR restore strobe and value.
REQ-014 The block SHALL have pc_load  output  1  and pc_out  output  32  PC redirect strobe and target.
REQ-015 The block SHALL have stall  output  1  pipeline freeze, and irq_ack  output  1  interrupt-taken pulse.

Function
REQ-016 States SHALL be IDLE, PUSH_PC, PUSH_CCR, FETCH_VEC, POP_CCR, POP_PC, DONE.
REQ-017 In IDLE, rti_req SHALL move to POP_CCR; else irq_req SHALL move to PUSH_PC; rti_req wins when both are high, with irq taken after that RTI completes.
REQ-018 On leaving IDLE, pc_in, ccr_in and sp_in SHALL be latched; an internal SP copy SHALL supply all addresses, and sp_in is not re-read mid-sequence.
REQ-019 Interrupt path: PUSH_PC writes latched PC at SP, then SP-1; PUSH_CCR writes {28'b0,flags} at SP-1, then SP-2; FETCH_VEC reads IRQ_VEC; then DONE.
REQ-020 RTI path: POP_CCR reads SP+1, POP_PC reads SP+2, then DONE.
REQ-021 Each memory state SHALL hold mem_req=1 with stable addr/we/wdata until mem_ack=1 is sampled; the state advances on the next edge; mem_ack with mem_req=0 SHALL be ignored.
REQ-022 mem_we SHALL be 1 only in PUSH_PC and PUSH_CCR.
REQ-023 sp_dec SHALL pulse for one cycle on each push ack; sp_inc SHALL pulse on each pop ack; net change is -2 per interrupt and +2 per RTI.
REQ-024 ccr_load_stack SHALL pulse on the POP_CCR ack cycle, with ccr_stack_flags=mem_rdata[3:0] in that cycle.
REQ-025 pc_load SHALL pulse on the ack cycle of FETCH_VEC or POP_PC, with pc_out=mem_rdata in that cycle.
REQ-026 DONE SHALL last exactly one cycle and return to IDLE; irq_ack SHALL pulse in DONE only for the interrupt path.
REQ-027 stall SHALL be 1 in every non-IDLE state and, combinationally, in IDLE while irq_req or rti_req is high.
REQ-028 irq_req/rti_req SHALL be ignored outside IDLE; there is no nesting.
REQ-029 Address arithmetic SHALL be 32-bit modulo 2^32; SP=0 push wraps to 32'hFFFF_FFFF.
REQ-030 Minimum latency with zero-wait ack SHALL be 4 cycles for an interrupt and 3 cycles for RTI, from IDLE acceptance to DONE.

Reset
REQ-031 When rst_n=0, state SHALL be IDLE and every output SHALL be 0, asynchronously.
REQ-032 Reset mid-sequence SHALL abort with no further strobes; a partially adjusted SP is the owner's concern.

Verification
REQ-033 Interrupt path: sp_in=0x100, pc_in=0x40, ccr_in=4'b0101, mem[0]=0x200, ack same cycle -> writes 0x40@0x100, 0x5@0xFF; read 0x0; pc_load with 0x200; two sp_dec; irq_ack in DONE.
REQ-034 RTI path: sp_in=0xFE, mem[0xFF]=0xA, mem[0x100]=0x44 -> ccr_load_stack with 4'b1010 then pc_load with 0x44; two sp_inc.
REQ-035 Wait states: mem_ack delayed 3 cycles in PUSH_CCR -> addr 0xFF and wdata held stable, single sp_dec, stall stays 1.
REQ-036 Simultaneous irq_req and rti_req in IDLE -> RTI sequence first, then the interrupt sequence starts with no extra requests.
REQ-037 rst_n low during POP_PC -> all outputs 0 immediately, no pc_load, IDLE after release.
REQ-038 sp_in=0 on interrupt -> writes at 0x0 then 0xFFFF_FFFF.
